mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-core memory arbiter that shares the single RAM port between the instruction and data ports of both caches. It sits between the two cache blocks and the RAM interface, alongside coherence control. It grants one access at a time with round-robin fairness between cores and fixed data-over-instruction priority within a core. A lock input lets a core hold the RAM across multi-word block fills and writebacks.

## Interface
Parameters:
- CPUS, 2: number of cores; fixed at 2 for this revision.
- WORD_W, 32: address and data width.

Ports:
- CLK  in  1  clock; rising edge.
- RST  in  1  reset; synchronous, active-high.
- iREN  in  2  instruction read request, one bit per core.
- dREN  in  2  data read request, per core.
- dWEN  in  2  data write request, per core.
- dlock  in  2  hold grant after the current data access completes, per core.
- iaddr  in  2×WORD_W  instruction address, per core.
- daddr  in  2×WORD_W  data address, per core.
- dstore  in  2×WORD_W  write data, per core.
- iwait  out  2  instruction access not complete, per core.
- dwait  out  2  data access not complete, per core.
- iload  out  2×WORD_W  read data; every element equals ramload.
- dload  out  2×WORD_W  read data; every element equals ramload.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

## Operation
- Requesters hold request, address and store data stable until their wait bit is low.
- Per-core request: `req[c] = iREN[c] | dREN[c] | dWEN[c]`.
- Within a core, the selected kind is chosen at grant time with priority dWEN > dREN > iREN. The selected kind is latched for the whole transaction.
- Registered state: `state` ∈ {IDLE, GRANT, LOCKED}, `owner` (1 bit), `kind` ∈ {I, DR, DW}, `rr` (1 bit; the core that wins a tie).
- IDLE:
  - RAM outputs are inactive: ramREN = ramWEN = 0, ramaddr = 0, ramstore = 0.
  - If any req is high: owner ← the sole requester, or rr if both request; kind latched; go to GRANT.
- GRANT:
  - Drive ramaddr/ramstore/ramREN/ramWEN from owner and kind. DW drives ramWEN=1 with daddr/dstore. DR drives ramREN=1 with daddr. I drives ramREN=1 with iaddr.
  - ramstate FREE or BUSY: stay in GRANT.
  - ramstate ERROR: stay in GRANT and re-present the access. The error is not reported upstream.
  - ramstate ACCESS: the owner's selected wait bit goes low this cycle; rr ← ~owner.
    - If kind ≠ I and dlock[owner]=1: go to LOCKED.
    - Otherwise: go to IDLE.
- LOCKED:
  - No RAM enables are driven; the owner keeps the grant.
  - Owner has dREN or dWEN high: re-latch kind (DW > DR) and go to GRANT. The other core is not considered.
  - dlock[owner]=0: go to IDLE.
  - The owner's iREN is ignored while LOCKED.
- Wait outputs (combinational): `iwait[c] = iREN[c] & ~done_i[c]`, `dwait[c] = (dREN[c]|dWEN[c]) & ~done_d[c]`.
  - done_x[c] is high only in GRANT with owner=c, kind of class x, and ramstate=ACCESS.
  - The non-selected kind of the owning core keeps waiting.

## Timing
- Reset: state=IDLE, owner=0, kind=I, rr=0. All RAM outputs are 0. Wait bits follow their combinational definition (high for any active request).
- RST sampled high mid-transaction aborts the transaction. ramREN/ramWEN are 0 from the next cycle.
- Minimum latency: request in cycle N (IDLE) → RAM driven in N+1 → if ACCESS in N+1, wait drops in N+1 → IDLE in N+2.
- Back-to-back requests from one core cost one IDLE bubble between accesses unless locked.
- Locked block transfer: one LOCKED cycle between words. The other core waits until dlock drops.
- Simultaneous requests with no lock: accesses strictly alternate between cores.
- A request dropped while GRANT is pending is a protocol violation; the arbiter completes the RAM access anyway.

## Test plan
- Reset, then core0 dREN with daddr=0x100 and ramstate ACCESS at the first grant cycle → ramREN=1, ramaddr=0x100 in cycle 1; dwait[0]=0 in cycle 1; IDLE in cycle 2.
- Both cores issue iREN continuously (iaddr 0x0 / 0x200), RAM answers ACCESS in 1 cycle → grants alternate 0,1,0,1; neither core waits more than 2 grant slots.
- Core0 has iREN, dWEN (daddr=0x40, dstore=0xDEADBEEF) and iREN simultaneously → write granted first (ramWEN=1, ramstore=0xDEADBEEF); iwait[0] stays 1 until the following grant.
- Core1 holds dlock=1 for 4 dREN words (0x300–0x30C) while core0 requests iREN → all 4 core1 accesses complete before core0 gets ramREN.
- ramstate sequence BUSY, ERROR, ACCESS on one grant → address held for 3 cycles; wait drops only on ACCESS.
- RST asserted in GRANT with ramstate BUSY → next cycle ramREN=ramWEN=0, state IDLE, rr=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-core RAM port arbiter: round-robin between cores, dWEN > dREN > iREN within a core,
// and a per-core data lock that holds the grant across multi-word block transfers.
module mem_arbiter #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [CPUS-1:0]              iREN,
  input  logic [CPUS-1:0]              dREN,
  input  logic [CPUS-1:0]              dWEN,
  input  logic [CPUS-1:0]              dlock,
  input  logic [CPUS-1:0][WORD_W-1:0]  iaddr,
  input  logic [CPUS-1:0][WORD_W-1:0]  daddr,
  input  logic [CPUS-1:0][WORD_W-1:0]  dstore,
  output logic [CPUS-1:0]              iwait,
  output logic [CPUS-1:0]              dwait,
  output logic [CPUS-1:0][WORD_W-1:0]  iload,
  output logic [CPUS-1:0][WORD_W-1:0]  dload,
  output logic [WORD_W-1:0]            ramaddr,
  output logic [WORD_W-1:0]            ramstore,
  output logic                         ramREN,
  output logic                         ramWEN,
  input  logic [WORD_W-1:0]            ramload,
  input  logic [1:0]                   ramstate
);

  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;
  typedef enum logic [1:0] {K_I, K_DR, K_DW} kind_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  state_t          state, state_nx;
  kind_t           kind, kind_nx;
  logic            owner, owner_nx;
  logic            rr, rr_nx;
  logic            sel;
  logic [CPUS-1:0] req;
  logic [CPUS-1:0] done_i, done_d;

  function automatic kind_t pick_kind(input logic w, input logic r);
    if (w)      return K_DW;
    else if (r) return K_DR;
    else        return K_I;
  endfunction

  assign req = iREN | dREN | dWEN;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      owner <= 1'b0;
      kind  <= K_I;
      rr    <= 1'b0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      kind  <= kind_nx;
      rr    <= rr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    kind_nx  = kind;
    rr_nx    = rr;
    sel      = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    done_i   = '0;
    done_d   = '0;
    case (state)
      IDLE: begin
        if (|req) begin
          // rr only breaks ties; a sole requester always wins
          sel      = (req[0] & req[1]) ? rr : req[1];
          owner_nx = sel;
          kind_nx  = pick_kind(dWEN[sel], dREN[sel]);
          state_nx = GRANT;
        end
      end
      GRANT: begin
        case (kind)
          K_DW: begin
            ramWEN   = 1'b1;
            ramaddr  = daddr[owner];
            ramstore = dstore[owner];
          end
          K_DR: begin
            ramREN  = 1'b1;
            ramaddr = daddr[owner];
          end
          default: begin
            ramREN  = 1'b1;
            ramaddr = iaddr[owner];
          end
        endcase
        // FREE, BUSY and ERROR all keep presenting the same access
        if (ramstate == RAM_ACCESS) begin
          if (kind == K_I) done_i[owner] = 1'b1;
          else             done_d[owner] = 1'b1;
          rr_nx = ~owner;
          if (kind != K_I && dlock[owner]) state_nx = LOCKED;
          else                             state_nx = IDLE;
        end
      end
      LOCKED: begin
        if (dWEN[owner] | dREN[owner]) begin
          kind_nx  = pick_kind(dWEN[owner], dREN[owner]);
          state_nx = GRANT;
        end else if (!dlock[owner]) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign iwait = iREN & ~done_i;
  assign dwait = (dREN | dWEN) & ~done_d;
  assign iload = {CPUS{ramload}};
  assign dload = {CPUS{ramload}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1 ns after each rising edge,
// outputs are checked 2 ns after the edge with hand-computed expectations.
module tb_mem_arbiter;

  localparam int W = 32;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic              CLK, RST;
  logic [1:0]        iREN, dREN, dWEN, dlock;
  logic [1:0][W-1:0] iaddr, daddr, dstore;
  logic [1:0]        iwait, dwait;
  logic [1:0][W-1:0] iload, dload;
  logic [W-1:0]      ramaddr, ramstore, ramload;
  logic              ramREN, ramWEN;
  logic [1:0]        ramstate;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.CPUS(2), .WORD_W(W)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .dlock(dlock),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0; dlock = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_inputs();
    tick();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    tick();
    // reset state: RAM idle, waits follow requests combinationally
    dREN = 2'b01;
    settle();
    chk("rst_ramREN", {31'b0, ramREN}, 0);
    chk("rst_ramWEN", {31'b0, ramWEN}, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_dwait", {30'b0, dwait}, 32'h1);
    do_reset();

    // minimum latency data read
    dREN = 2'b01; daddr[0] = 32'h100; ramload = 32'hCAFE0001;
    settle();
    chk("lat_c0_ramREN", {31'b0, ramREN}, 0);
    chk("lat_c0_dwait", {30'b0, dwait}, 32'h1);
    tick();
    ramstate = ACCESS;
    settle();
    chk("lat_c1_ramREN", {31'b0, ramREN}, 1);
    chk("lat_c1_ramaddr", ramaddr, 32'h100);
    chk("lat_c1_dwait", {30'b0, dwait}, 0);
    chk("lat_c1_dload", dload[0], 32'hCAFE0001);
    chk("lat_c1_iload", iload[1], 32'hCAFE0001);
    tick();
    dREN = 2'b00;
    settle();
    chk("lat_c2_ramREN", {31'b0, ramREN}, 0);
    chk("lat_c2_ramaddr", ramaddr, 0);

    // round robin on continuous instruction fetches
    do_reset();
    iREN = 2'b11; iaddr[0] = 32'h0; iaddr[1] = 32'h200; ramstate = ACCESS;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("rr%0d_idle_ramREN", k), {31'b0, ramREN}, 0);
      tick();
      settle();
      chk($sformatf("rr%0d_ramREN", k), {31'b0, ramREN}, 1);
      chk($sformatf("rr%0d_ramaddr", k), ramaddr, (k % 2 == 1) ? 32'h200 : 32'h0);
      chk($sformatf("rr%0d_iwait", k), {30'b0, iwait}, (k % 2 == 1) ? 32'h1 : 32'h2);
      tick();
    end

    // write beats instruction fetch within a core
    do_reset();
    iREN = 2'b01; iaddr[0] = 32'h80;
    dWEN = 2'b01; daddr[0] = 32'h40; dstore[0] = 32'hDEADBEEF; ramstate = ACCESS;
    settle();
    chk("pri_c0_iwait", {30'b0, iwait}, 32'h1);
    tick();
    settle();
    chk("pri_c1_ramWEN", {31'b0, ramWEN}, 1);
    chk("pri_c1_ramREN", {31'b0, ramREN}, 0);
    chk("pri_c1_ramstore", ramstore, 32'hDEADBEEF);
    chk("pri_c1_ramaddr", ramaddr, 32'h40);
    chk("pri_c1_dwait", {30'b0, dwait}, 0);
    chk("pri_c1_iwait", {30'b0, iwait}, 32'h1);
    tick();
    dWEN = 2'b00;
    settle();
    chk("pri_c2_ramWEN", {31'b0, ramWEN}, 0);
    chk("pri_c2_iwait", {30'b0, iwait}, 32'h1);
    tick();
    settle();
    chk("pri_c3_ramREN", {31'b0, ramREN}, 1);
    chk("pri_c3_ramaddr", ramaddr, 32'h80);
    chk("pri_c3_iwait", {30'b0, iwait}, 0);
    tick();
    iREN = 2'b00;

    // locked four-word block read by core 1, core 0 fetch held off
    do_reset();
    dREN = 2'b10; dlock = 2'b10; daddr[1] = 32'h300; ramstate = ACCESS;
    iaddr[0] = 32'h10;
    tick();
    iREN = 2'b01;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("lk%0d_ramREN", k), {31'b0, ramREN}, 1);
      chk($sformatf("lk%0d_ramaddr", k), ramaddr, 32'h300 + 32'(4 * k));
      chk($sformatf("lk%0d_dwait", k), {30'b0, dwait}, 0);
      chk($sformatf("lk%0d_iwait", k), {30'b0, iwait}, 32'h1);
      tick();
      if (k < 3) begin
        daddr[1] = 32'h300 + 32'(4 * (k + 1));
        settle();
        chk($sformatf("lk%0d_gap_ramREN", k), {31'b0, ramREN}, 0);
        chk($sformatf("lk%0d_gap_dwait", k), {30'b0, dwait}, 32'h2);
        tick();
      end
    end
    dREN = 2'b00; dlock = 2'b00;
    settle();
    chk("lk_end_ramREN", {31'b0, ramREN}, 0);
    tick();
    settle();
    chk("lk_idle_ramREN", {31'b0, ramREN}, 0);
    tick();
    settle();
    chk("lk_c0_ramREN", {31'b0, ramREN}, 1);
    chk("lk_c0_ramaddr", ramaddr, 32'h10);
    chk("lk_c0_iwait", {30'b0, iwait}, 0);
    tick();
    iREN = 2'b00;

    // BUSY and ERROR stretch the grant until ACCESS
    do_reset();
    iREN = 2'b10; iaddr[1] = 32'h500;
    tick();
    ramstate = BUSY;
    settle();
    chk("st_busy_ramaddr", ramaddr, 32'h500);
    chk("st_busy_iwait", {30'b0, iwait}, 32'h2);
    tick();
    ramstate = ERROR;
    settle();
    chk("st_err_ramaddr", ramaddr, 32'h500);
    chk("st_err_ramREN", {31'b0, ramREN}, 1);
    chk("st_err_iwait", {30'b0, iwait}, 32'h2);
    tick();
    ramstate = ACCESS;
    settle();
    chk("st_acc_ramaddr", ramaddr, 32'h500);
    chk("st_acc_iwait", {30'b0, iwait}, 0);
    tick();
    iREN = 2'b00;
    settle();
    chk("st_done_ramREN", {31'b0, ramREN}, 0);

    // reset mid-grant; core 0 completing first leaves rr=1 unless reset clears it
    iREN = 2'b01; iaddr[0] = 32'h20;
    tick();
    tick();
    iREN = 2'b00;
    dWEN = 2'b01; daddr[0] = 32'h44; dstore[0] = 32'h1234;
    tick();
    ramstate = BUSY;
    settle();
    chk("ra_grant_ramWEN", {31'b0, ramWEN}, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    dREN = 2'b10; daddr[1] = 32'h600; ramstate = ACCESS;
    settle();
    chk("ra_after_ramWEN", {31'b0, ramWEN}, 0);
    chk("ra_after_ramREN", {31'b0, ramREN}, 0);
    chk("ra_after_ramaddr", ramaddr, 0);
    tick();
    settle();
    chk("ra_tie_ramWEN", {31'b0, ramWEN}, 1);
    chk("ra_tie_ramaddr", ramaddr, 32'h44);
    chk("ra_tie_dwait", {30'b0, dwait}, 32'h2);
    tick();
    dWEN = 2'b00;
    tick();
    settle();
    chk("ra_c1_ramREN", {31'b0, ramREN}, 1);
    chk("ra_c1_ramaddr", ramaddr, 32'h600);
    chk("ra_c1_dwait", {30'b0, dwait}, 0);
    tick();
    dREN = 2'b00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
